// File: rtl/ahb_arb_pkg.sv
// Shared types and constants for the two-port AHB master arbiter.
package ahb_arb_pkg;

    localparam int NUM_PORTS  = 2;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA
    } arb_state_t;

    typedef logic [$clog2(NUM_PORTS)-1:0] owner_t;

endpackage

// File: rtl/ahb_master_arbiter_if.sv
// Requester ports plus AHB master user-side signals; "master" is the arbiter's view,
// "slave" is the environment's view (requesters and the AHB master block).
interface ahb_master_arbiter_if #(
    parameter int ADDR_W = ahb_arb_pkg::DEF_ADDR_W,
    parameter int DATA_W = ahb_arb_pkg::DEF_DATA_W
);
    logic              p0_req;
    logic              p0_write;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_gnt;
    logic              p0_done;
    logic [DATA_W-1:0] p0_rdata;

    logic              p1_req;
    logic              p1_write;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_gnt;
    logic              p1_done;
    logic [DATA_W-1:0] p1_rdata;

    logic              transfer;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              HREADY;

    modport master (
        input  p0_req, p0_write, p0_addr, p0_wdata,
        output p0_gnt, p0_done, p0_rdata,
        input  p1_req, p1_write, p1_addr, p1_wdata,
        output p1_gnt, p1_done, p1_rdata,
        output transfer, write, addr, wdata,
        input  rdata, HREADY
    );

    modport slave (
        output p0_req, p0_write, p0_addr, p0_wdata,
        input  p0_gnt, p0_done, p0_rdata,
        output p1_req, p1_write, p1_addr, p1_wdata,
        input  p1_gnt, p1_done, p1_rdata,
        input  transfer, write, addr, wdata,
        output rdata, HREADY
    );

endinterface

// File: rtl/ahb_arb_picker.sv
// Winner select for two requesters; fixed priority to port 0 unless ARB_ROUND_ROBIN_EN,
// which adds a last-served pointer (reset to port 1) updated on every grant.
module ahb_arb_picker
    import ahb_arb_pkg::*;
(
    input  logic   req0,
    input  logic   req1,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic   clk,
    input  logic   rst_n,
    input  logic   grant,
`endif
    output owner_t winner
);

`ifdef ARB_ROUND_ROBIN_EN
    owner_t last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= owner_t'(1);
        end else if (grant) begin
            last_q <= winner;
        end
    end

    // On a tie, port 1 wins only if port 0 was served last.
    always_comb begin
        winner = owner_t'(0);
        if (req1 && (!req0 || last_q == owner_t'(0))) begin
            winner = owner_t'(1);
        end
    end
`else
    always_comb begin
        winner = owner_t'(0);
        if (req1 && !req0) begin
            winner = owner_t'(1);
        end
    end
`endif

endmodule

// File: rtl/ahb_master_arbiter.sv
// Shares one AHB master between data (p0) and fetch (p1) ports; one transfer in flight,
// gnt->done in 3 cycles plus one per HREADY-low cycle. Tie policy set by ARB_ROUND_ROBIN_EN.
module ahb_master_arbiter
    import ahb_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
)(
    input  logic                 HCLK,
    input  logic                 HRESETn,
    ahb_master_arbiter_if.master bus
);

    arb_state_t        state_q, state_d;
    owner_t            winner, owner_q;
    logic              any_req, grant, data_done;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] p0_rdata_q, p1_rdata_q;
    logic              p0_done_q, p1_done_q;

    assign any_req = bus.p0_req | bus.p1_req;

    ahb_arb_picker u_picker (
        .req0   (bus.p0_req),
        .req1   (bus.p1_req),
`ifdef ARB_ROUND_ROBIN_EN
        .clk    (HCLK),
        .rst_n  (HRESETn),
        .grant  (grant),
`endif
        .winner (winner)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (any_req)    state_d = ST_ADDR;
            ST_ADDR: if (bus.HREADY) state_d = ST_DATA;
            ST_DATA: if (bus.HREADY) state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // Grant is gated by reset so nothing is accepted while the block is held in reset.
    always_comb begin
        grant        = 1'b0;
        bus.transfer = 1'b0;
        data_done    = 1'b0;
        case (state_q)
            ST_IDLE: grant        = any_req & HRESETn;
            ST_ADDR: bus.transfer = 1'b1;
            ST_DATA: data_done    = bus.HREADY;
            default: ;
        endcase
    end

    assign bus.p0_gnt = grant && (winner == owner_t'(0));
    assign bus.p1_gnt = grant && (winner == owner_t'(1));

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            owner_q <= owner_t'(0);
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (grant) begin
            owner_q <= winner;
            write_q <= (winner == owner_t'(1)) ? bus.p1_write : bus.p0_write;
            addr_q  <= (winner == owner_t'(1)) ? bus.p1_addr  : bus.p0_addr;
            wdata_q <= (winner == owner_t'(1)) ? bus.p1_wdata : bus.p0_wdata;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            p0_done_q  <= 1'b0;
            p1_done_q  <= 1'b0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
        end else begin
            p0_done_q <= data_done && (owner_q == owner_t'(0));
            p1_done_q <= data_done && (owner_q == owner_t'(1));
            if (data_done && !write_q && owner_q == owner_t'(0)) p0_rdata_q <= bus.rdata;
            if (data_done && !write_q && owner_q == owner_t'(1)) p1_rdata_q <= bus.rdata;
        end
    end

    assign bus.write    = write_q;
    assign bus.addr     = addr_q;
    assign bus.wdata    = wdata_q;
    assign bus.p0_done  = p0_done_q;
    assign bus.p1_done  = p1_done_q;
    assign bus.p0_rdata = p0_rdata_q;
    assign bus.p1_rdata = p1_rdata_q;

endmodule

// File: doc/ahb_master_arbiter.md
# ahb_master_arbiter

Two-port arbiter that shares the single AHB master interface of the microcontroller between the data (load/store) port and the instruction-fetch port. It sits between the core-side requesters and the AHB master's user interface (`transfer`, `write`, `addr`, `wdata`, `rdata`). It sequences each accepted request through the address and data phases and returns read data and a completion pulse to the owning port. One transfer is in flight at a time; there is no pipelining across requesters.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `HCLK`  in  1  system clock, all state on rising edge
- `HRESETn`  in  1  asynchronous, active-low reset
- `p0_req`  in  1  port 0 (data) request level
- `p0_write`  in  1  port 0 direction, 1 = write
- `p0_addr`  in  ADDR_W  port 0 address
- `p0_wdata`  in  DATA_W  port 0 write data
- `p0_gnt`  out  1  port 0 request accepted this cycle (combinational)
- `p0_done`  out  1  port 0 transfer complete, one-cycle pulse
- `p0_rdata`  out  DATA_W  port 0 read data, registered
- `p1_*`  same set for port 1 (instruction fetch)
- `transfer`  out  1  to AHB master, start of address phase
- `write`  out  1  to AHB master, direction
- `addr`  out  ADDR_W  to AHB master, address
- `wdata`  out  DATA_W  to AHB master, write data
- `rdata`  in  DATA_W  from AHB master, read data
- `HREADY`  in  1  bus ready, qualifies phase completion

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE: if any `pX_req`, the arbiter picks a winner and asserts the winner's `pX_gnt` combinationally. At that edge it latches the winner's write/addr/wdata and owner id, then moves to ADDR. If there is no request, it stays in IDLE.
- ADDR: `transfer`=1. `write` and `addr` come from the latches. When `HREADY`=1 the FSM moves to DATA; otherwise it holds ADDR with outputs stable.
- DATA: `transfer`=0 and `wdata` is driven from the latch. The FSM waits for `HREADY`=1. At that edge:
  - for a read, `rdata` is captured into the owner's `pX_rdata`;
  - the owner's `pX_done` is set for the next cycle;
  - the FSM returns to IDLE.
- Write completion pulses `pX_done` and leaves `pX_rdata` unchanged.
- A `pX_req` still high in the `pX_done` cycle is treated as a new request (valid/ready semantics). The requester must deassert `req` or present new fields after `gnt`.
- Arbitration with only one requester: that port wins.
- Arbitration with both requesting: the winner is set by the configuration macro (see Configuration).
- `addr`, `write` and `wdata` hold their last latched values in IDLE.
- `gnt` is never asserted outside IDLE.

## Timing
- Reset values:
  - FSM = IDLE;
  - `transfer`, `write`, `pX_gnt`, `pX_done` = 0;
  - `addr`, `wdata`, `pX_rdata` = 0;
  - round-robin pointer = "last served port 1", so port 0 wins the first tie.
- Minimum latency with `HREADY` held high:
  - gnt in cycle 0;
  - ADDR in cycle 1;
  - DATA in cycle 2;
  - `done` and `rdata` valid in cycle 3.
- Back-to-back: a new grant is possible in the `done` cycle, which gives a 3-cycle throughput per transfer.
- Each `HREADY`-low cycle in ADDR or DATA adds one cycle.
- Reset asserted mid-transfer forces IDLE immediately. The in-flight transfer is dropped with no `done`.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: on a tie, the port not served last wins. The pointer updates on every grant.
- Undefined: fixed priority, port 0 always wins a tie. The pointer logic is not compiled.

## Structure
- Package `ahb_arb_pkg`:
  - FSM state enum typedef;
  - `NUM_PORTS`=2;
  - default `ADDR_W` and `DATA_W` constants;
  - owner-id typedef.
- One sub-module, `ahb_arb_picker`: combinational winner select from the two requests and the last-served pointer, plus the pointer register. The pointer register sits under `ARB_ROUND_ROBIN_EN`.

## Test plan
- Reset: hold `HRESETn`=0 and drive both reqs -> all outputs 0, no gnt; after release, the first tie is granted to port 0.
- Single read, port 1:
  - stimulus: `p1_addr`=0x0000_000A, `HREADY`=1, `rdata`=0xBBBB_BBBB in DATA;
  - response: `p1_gnt` in cycle 0, `transfer`=1 with `addr`=0xA in cycle 1, `p1_done`=1 and `p1_rdata`=0xBBBB_BBBB in cycle 3.
- Single write, port 0:
  - stimulus: `addr`=0xC, `wdata`=0xAAAA_AAAA;
  - response: `write`=1 in ADDR, `wdata`=0xAAAA_AAAA in DATA, `p0_done` pulse, `p0_rdata` unchanged.
- Wait states: `HREADY`=0 for 2 cycles in DATA -> FSM stays in DATA and `wdata` is stable; `done` arrives 2 cycles late.
- Contention: both ports request continuously for 4 transfers.
  - With `ARB_ROUND_ROBIN_EN`: grant order 0,1,0,1.
  - Without it: order 0,0,0,0.
- Reset mid-DATA: drop `HRESETn` during DATA -> immediately IDLE, `transfer`=0, no `done`; the next request completes normally.
